// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter and its shifter datapath.
package shift_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    // Mirror a word end-for-end so a left shifter can serve a right shift.
    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrelshifter.sv
// 32-bit logical left barrel shifter, one log2 stage per shift-amount bit.
module barrelshifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [DATA_W-1:0]  data_o
);

    logic [DATA_W-1:0] stage;

    // Each stage shifts by 2^i when shamt bit i is set.
    always_comb begin
        stage = data_i;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt_i[i]) begin
                stage = stage << (1 << i);
            end
        end
        data_o = stage;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared shift unit.
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_op,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_op,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               out_valid,
    output logic               out_id,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready
);

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               op_q, op_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               id_q, id_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_id_q, out_id_d;

    logic               any_valid;
    logic               gnt_id;
    logic [DATA_W-1:0]  sh_in;
    logic [DATA_W-1:0]  sh_out;
    logic [DATA_W-1:0]  fill_mask;
    logic [DATA_W-1:0]  result;

    // Round-robin pick: the pointer only matters when both requesters compete.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        gnt_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    end

    barrelshifter u_shifter (
        .data_i  (sh_in),
        .shamt_i (shamt_q),
        .data_o  (sh_out)
    );

    // SRA reuses the left shifter on mirrored data, then restores sign bits via a mask.
    always_comb begin
        sh_in     = (op_q == OP_SLL) ? data_q : bit_reverse(data_q);
        fill_mask = (op_q == OP_SRA && data_q[DATA_W-1]) ?
                    ~({DATA_W{1'b1}} >> shamt_q) : '0;
        result    = (op_q == OP_SLL) ? sh_out : (bit_reverse(sh_out) | fill_mask);
    end

    // Next-state, grant and handshake logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        id_d       = id_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_valid && !reset) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    op_d       = gnt_id ? req1_op    : req0_op;
                    data_d     = gnt_id ? req1_data  : req0_data;
                    shamt_d    = gnt_id ? req1_shamt : req0_shamt;
                    id_d       = gnt_id;
                    state_d    = StExec;
                end
            end
            StExec: begin
                out_data_d = result;
                out_id_d   = id_q;
                state_d    = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ptr_d   = ~out_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and operand registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            op_q       <= 1'b0;
            data_q     <= '0;
            shamt_q    <= '0;
            id_q       <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            id_q       <= id_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    assign out_data = out_data_q;
    assign out_id   = out_id_q;

endmodule
